evm_tally: RTL and testbench

- Parametrised, clocked successor to the party-vote counter. It tallies votes for NUM_CAND candidates plus a NOTA channel.
- A poll-session FSM governs the block: IDLE, OPEN, SCAN, DONE.
- Votes enter through a valid/ready handshake. Counters saturate instead of wrapping.
- After close, a sequential scan produces a registered winner, winner count and tie flag for the display/report logic.

---
 rtl/evm_pkg.sv | 24 ++
 rtl/evm_sat_counter.sv | 40 ++++
 rtl/evm_tally.sv | 163 ++++++++++++++++
 tb/tb_evm_tally.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
`default_nettype none
// ============================================================================
// evm_pkg : shared poll-session state type and width helpers for evm_tally
// Rev 1.0 : initial release
// ============================================================================
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } poll_state_t;

    function automatic int sel_width(input int num_cand);
        return $clog2(num_cand + 1);
    endfunction

    function automatic int tot_width(input int cnt_w, input int num_cand);
        return cnt_w + $clog2(num_cand + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/evm_sat_counter.sv
`default_nettype none
// ============================================================================
// evm_sat_counter : per-channel vote counter that sticks at all-ones
// Rev 1.0 : initial release
// ============================================================================
module evm_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/evm_tally.sv
`default_nettype none
// ============================================================================
// evm_tally : poll-session vote tally with saturating counters and a
//             sequential winner scan over the eligible candidates
// Rev 1.0 : initial release
// ============================================================================
module evm_tally
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 8,
    parameter int CNT_W    = 8,
    parameter int SEL_W    = sel_width(NUM_CAND),
    parameter int TOT_W    = tot_width(CNT_W, NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open_poll,
    input  logic             close_poll,
    input  logic             clear_poll,
    input  logic             vote_valid,
    input  logic [SEL_W-1:0] vote_sel,
    output logic             vote_ready,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [TOT_W-1:0] total_votes,
    output logic             sat,
    output logic [1:0]       poll_state,
    output logic             result_valid,
    output logic [SEL_W-1:0] winner_idx,
    output logic [CNT_W-1:0] winner_cnt,
    output logic             tie
);

    localparam int               NUM_CH     = NUM_CAND + 1;
    localparam logic [SEL_W-1:0] c_NOTA_IDX = SEL_W'(NUM_CAND);
    localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(NUM_CAND - 1);

    poll_state_t      state_q,    state_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic [SEL_W-1:0] win_idx_q,  win_idx_d;
    logic [CNT_W-1:0] win_cnt_q,  win_cnt_d;
    logic             tie_q,      tie_d;
    logic [TOT_W-1:0] total_q,    total_d;
    logic             sat_q,      sat_d;

    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_at_max;
    logic [NUM_CH-1:0] w_inc;
    logic              w_accept;
    logic              w_clr;
    logic [SEL_W-1:0]  w_chan;
    logic [CNT_W-1:0]  w_scan_cnt;

    // Out-of-range selectors fold onto the NOTA channel.
    assign w_accept   = vote_valid && (state_q == OPEN);
    assign w_chan     = (vote_sel > c_NOTA_IDX) ? c_NOTA_IDX : vote_sel;
    assign w_clr      = (state_q == DONE) && clear_poll;
    assign w_scan_cnt = w_cnt[scan_idx_q];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_inc[i] = w_accept && (w_chan == SEL_W'(i));

        evm_sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (w_clr),
            .inc    (w_inc[i]),
            .cnt    (w_cnt[i]),
            .at_max (w_at_max[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        win_idx_d  = win_idx_q;
        win_cnt_d  = win_cnt_q;
        tie_d      = tie_q;
        total_d    = total_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (open_poll) state_d = OPEN;
            end
            OPEN: begin
                if (w_accept) begin
                    if (w_at_max[w_chan]) sat_d   = 1'b1;
                    else                  total_d = total_q + TOT_W'(1);
                end
                if (close_poll) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                end
            end
            SCAN: begin
                // Strict greater-than keeps the lowest index on equal counts.
                if (scan_idx_q == '0) begin
                    win_idx_d = '0;
                    win_cnt_d = w_scan_cnt;
                    tie_d     = 1'b0;
                end else if (w_scan_cnt > win_cnt_q) begin
                    win_idx_d = scan_idx_q;
                    win_cnt_d = w_scan_cnt;
                    tie_d     = 1'b0;
                end else if (w_scan_cnt == win_cnt_q) begin
                    tie_d = 1'b1;
                end
                if (scan_idx_q == c_LAST_IDX) begin
                    state_d = DONE;
                    if (win_cnt_d == '0) tie_d = 1'b1;
                end else begin
                    scan_idx_d = scan_idx_q + SEL_W'(1);
                end
            end
            DONE: begin
                if (clear_poll) begin
                    state_d    = IDLE;
                    scan_idx_d = '0;
                    win_idx_d  = '0;
                    win_cnt_d  = '0;
                    tie_d      = 1'b0;
                    total_d    = '0;
                    sat_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            win_idx_q  <= '0;
            win_cnt_q  <= '0;
            tie_q      <= 1'b0;
            total_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            win_idx_q  <= win_idx_d;
            win_cnt_q  <= win_cnt_d;
            tie_q      <= tie_d;
            total_q    <= total_d;
            sat_q      <= sat_d;
        end
    end

    assign vote_ready   = (state_q == OPEN);
    assign result_valid = (state_q == DONE);
    assign poll_state   = state_q;
    assign rd_cnt       = (rd_idx > c_NOTA_IDX) ? '0 : w_cnt[rd_idx];
    assign total_votes  = total_q;
    assign sat          = sat_q;
    assign winner_idx   = win_idx_q;
    assign winner_cnt   = win_cnt_q;
    assign tie          = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_evm_tally.sv
`default_nettype none
// ============================================================================
// tb_evm_tally : randomized scoreboard bench for evm_tally (NUM_CAND=8, CNT_W=2)
// Rev 1.0 : initial release
// ============================================================================
module tb_evm_tally;

    localparam int NC   = 8;
    localparam int CW   = 2;
    localparam int SW   = 4;
    localparam int TW   = 6;
    localparam int CMAX = 3;

    logic          clk, rst_n;
    logic          open_poll, close_poll, clear_poll, vote_valid;
    logic [SW-1:0] vote_sel, rd_idx, winner_idx;
    logic          vote_ready, sat, result_valid, tie;
    logic [CW-1:0] rd_cnt, winner_cnt;
    logic [TW-1:0] total_votes;
    logic [1:0]    poll_state;

    evm_tally #(.NUM_CAND(NC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .open_poll    (open_poll),
        .close_poll   (close_poll),
        .clear_poll   (clear_poll),
        .vote_valid   (vote_valid),
        .vote_sel     (vote_sel),
        .vote_ready   (vote_ready),
        .rd_idx       (rd_idx),
        .rd_cnt       (rd_cnt),
        .total_votes  (total_votes),
        .sat          (sat),
        .poll_state   (poll_state),
        .result_valid (result_valid),
        .winner_idx   (winner_idx),
        .winner_cnt   (winner_cnt),
        .tie          (tie)
    );

    typedef struct {
        int win;
        int wcnt;
        int tie;
        int total;
        int sat;
        int close_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   rd_q[$];
    logic rd_strobe;
    int   cnt_m [NC+1];
    int   tot_m, sat_m;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: plain per-channel tallies and an argmax over candidates.
    task automatic model_clear();
        for (int i = 0; i <= NC; i++) cnt_m[i] = 0;
        tot_m = 0;
        sat_m = 0;
    endtask

    task automatic model_vote(input int sel);
        int ch;
        ch = (sel > NC) ? NC : sel;
        if (cnt_m[ch] == CMAX) sat_m = 1;
        else begin
            cnt_m[ch]++;
            tot_m++;
        end
    endtask

    function automatic exp_t model_result(input int ccyc);
        exp_t e;
        int   best, n;
        best = 0;
        for (int i = 0; i < NC; i++) if (cnt_m[i] > best) best = cnt_m[i];
        n     = 0;
        e.win = 0;
        for (int i = 0; i < NC; i++) begin
            if (cnt_m[i] == best) begin
                if (n == 0) e.win = i;
                n++;
            end
        end
        e.wcnt      = best;
        e.tie       = (n >= 2 || best == 0) ? 1 : 0;
        e.total     = tot_m;
        e.sat       = sat_m;
        e.close_cyc = ccyc;
        return e;
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a result or a readback.
    initial begin
        logic prev_rv;
        exp_t e;
        int   v;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1 && prev_rv !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_result actual=result required=none");
                end else begin
                    e = sb_q.pop_front();
                    chk("winner_idx", winner_idx, e.win);
                    chk("winner_cnt", winner_cnt, e.wcnt);
                    chk("tie", tie, e.tie);
                    chk("total_votes", total_votes, e.total);
                    chk("sat", sat, e.sat);
                    chk("result_latency", cyc - e.close_cyc, NC);
                end
            end
            prev_rv = result_valid;
            if (rd_strobe === 1'b1 && rd_q.size() > 0) begin
                v = rd_q.pop_front();
                chk("rd_cnt", rd_cnt, v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_s();
        open_poll = 1'b1;
        tick();
        open_poll = 1'b0;
        chk("state_open", poll_state, 1);
    endtask

    task automatic vote(input int sel);
        chk("vote_ready", vote_ready, 1);
        vote_valid = 1'b1;
        vote_sel   = SW'(sel);
        model_vote(sel);
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic close_s(input bit wv, input int sel);
        if (wv) begin
            vote_valid = 1'b1;
            vote_sel   = SW'(sel);
            model_vote(sel);
        end
        close_poll = 1'b1;
        sb_q.push_back(model_result(cyc + 1));
        tick();
        close_poll = 1'b0;
        vote_valid = 1'b0;
        chk("ready_after_close", vote_ready, 0);
        chk("state_scan", poll_state, 2);
    endtask

    task automatic wait_done(input bit junk);
        for (int k = 0; k < NC + 10 && result_valid !== 1'b1; k++) begin
            chk("scan_ready_low", vote_ready, 0);
            if (junk) begin
                vote_valid = 1'($urandom_range(0, 1));
                vote_sel   = SW'($urandom_range(0, 15));
                open_poll  = 1'($urandom_range(0, 1));
                clear_poll = 1'($urandom_range(0, 1));
                close_poll = 1'($urandom_range(0, 1));
            end
            tick();
        end
        vote_valid = 1'b0;
        open_poll  = 1'b0;
        clear_poll = 1'b0;
        close_poll = 1'b0;
        chk("done_reached", result_valid, 1);
    endtask

    task automatic readback();
        for (int i = 0; i < 16; i++) begin
            rd_idx = SW'(i);
            rd_q.push_back((i > NC) ? 0 : cnt_m[i]);
            rd_strobe = 1'b1;
            tick();
        end
        rd_strobe = 1'b0;
        rd_idx    = '0;
    endtask

    task automatic finish_s();
        open_poll = 1'b1;
        tick();
        open_poll = 1'b0;
        chk("done_ignores_open", poll_state, 3);
        clear_poll = 1'b1;
        tick();
        clear_poll = 1'b0;
        model_clear();
        chk("clear_state", poll_state, 0);
        chk("clear_total", total_votes, 0);
        chk("clear_sat", sat, 0);
        chk("clear_winner", winner_idx, 0);
        chk("clear_wcnt", winner_cnt, 0);
        chk("clear_tie", tie, 0);
        chk("clear_rv", result_valid, 0);
        clear_poll = 1'b1;
        close_poll = 1'b1;
        vote_valid = 1'b1;
        vote_sel   = SW'(1);
        tick();
        clear_poll = 1'b0;
        close_poll = 1'b0;
        vote_valid = 1'b0;
        chk("idle_hold", poll_state, 0);
        chk("idle_no_vote", total_votes, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        open_poll  = 1'b0;
        close_poll = 1'b0;
        clear_poll = 1'b0;
        vote_valid = 1'b0;
        vote_sel   = '0;
        rd_idx     = '0;
        rd_strobe  = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", poll_state, 0);
        chk("rst_ready", vote_ready, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_total", total_votes, 0);
        chk("rst_sat", sat, 0);
        chk("rst_winner", winner_idx, 0);
        chk("rst_wcnt", winner_cnt, 0);
        chk("rst_tie", tie, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", poll_state, 0);

        // Plurality winner with NOTA and out-of-range selectors.
        open_s();
        vote(1); vote(1); vote(3); vote(8); vote(15);
        close_s(1'b0, 0);
        wait_done(1'b0);
        chk("d1_winner", winner_idx, 1);
        chk("d1_wcnt", winner_cnt, 2);
        chk("d1_tie", tie, 0);
        chk("d1_total", total_votes, 5);
        rd_idx = SW'(8);
        #1;
        chk("d1_nota_cnt", rd_cnt, 2);
        readback();
        finish_s();

        // Two-way tie keeps the lowest index.
        open_s();
        vote(2); vote(5); vote(5); vote(2);
        close_s(1'b0, 0);
        wait_done(1'b0);
        chk("d2_tie", tie, 1);
        chk("d2_winner", winner_idx, 2);
        chk("d2_wcnt", winner_cnt, 2);
        readback();
        finish_s();

        // Empty poll.
        open_s();
        close_s(1'b0, 0);
        wait_done(1'b0);
        chk("d3_tie", tie, 1);
        chk("d3_winner", winner_idx, 0);
        chk("d3_wcnt", winner_cnt, 0);
        chk("d3_total", total_votes, 0);
        finish_s();

        // Saturation: the fourth vote is acked but dropped.
        open_s();
        vote(0); vote(0); vote(0); vote(0);
        chk("d4_total", total_votes, 3);
        chk("d4_sat", sat, 1);
        rd_idx = '0;
        #1;
        chk("d4_cnt0", rd_cnt, 3);
        close_s(1'b0, 0);
        wait_done(1'b0);
        finish_s();

        // Vote coincident with close is counted; scan ignores everything.
        open_s();
        vote(4);
        close_s(1'b1, 4);
        chk("d5_total", total_votes, 2);
        wait_done(1'b1);
        chk("d5_wcnt", winner_cnt, 2);
        readback();
        finish_s();

        // Asynchronous reset mid-scan.
        open_s();
        vote(6); vote(7); vote(7);
        close_s(1'b0, 0);
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        rd_idx = SW'(7);
        #1;
        chk("arst_state", poll_state, 0);
        chk("arst_total", total_votes, 0);
        chk("arst_winner", winner_idx, 0);
        chk("arst_wcnt", winner_cnt, 0);
        chk("arst_rd_cnt", rd_cnt, 0);
        sb_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-open.
        open_s();
        vote(3); vote(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_open_state", poll_state, 0);
        chk("arst_open_ready", vote_ready, 0);
        chk("arst_open_total", total_votes, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int s = 0; s < 15; s++) begin
            int nv, mode, sel;
            nv   = $urandom_range(0, 24);
            mode = $urandom_range(0, 2);
            open_s();
            for (int v = 0; v < nv; v++) begin
                if (mode == 0)      sel = $urandom_range(0, 15);
                else if (mode == 1) sel = $urandom_range(0, 2);
                else                sel = $urandom_range(0, 9);
                if ($urandom_range(0, 3) == 0) tick();
                vote(sel);
            end
            close_s(1'($urandom_range(0, 1)), $urandom_range(0, 15));
            wait_done(1'b1);
            readback();
            finish_s();
        end

        chk("sb_drained", sb_q.size(), 0);
        chk("rd_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
